// File: rtl/stack_pkg.sv
// Shared types and defaults for the 6502 stack sequencer: command opcodes,
// sequencer states and the stack-page address helper.
package stack_pkg;

  localparam logic [7:0] DEF_STACK_PAGE = 8'h01;
  localparam logic [7:0] DEF_RESET_SP   = 8'hFF;

  typedef enum logic [2:0] {
    OP_PUSH1 = 3'd0,
    OP_PUSH2 = 3'd1,
    OP_PULL1 = 3'd2,
    OP_PULL2 = 3'd3,
    OP_LOAD  = 3'd4
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_HI  = 3'd1,
    ST_PUSH_LO  = 3'd2,
    ST_PULL_RD  = 3'd3,
    ST_PULL_CAP = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  function automatic logic [15:0] stack_addr(input logic [7:0] page, input logic [7:0] ptr);
    return {page, ptr};
  endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Command handshake plus shared memory port between the control FSM,
// the stack sequencer and the memory mux.
interface stack_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        done;
  logic [15:0] pull_data;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_data, mem_rdata,
    input  cmd_ready, done, pull_data, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, mem_rdata,
    output cmd_ready, done, pull_data, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/stack_ptr.sv
// 8-bit stack pointer with increment/decrement/load. With STACK_OVF_EN the
// wrap output is a sticky flag for 00->FF / FF->00 wraps, cleared by load.
module stack_ptr
  import stack_pkg::*;
#(
  parameter logic [7:0] RESET_SP = DEF_RESET_SP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] sp,
  output logic [7:0] sp_next,
  output logic       wrap
);

  // next pointer value, also exported so callers can register addresses ahead
  always_comb begin
    sp_next = sp;
    if (load) begin
      sp_next = load_val;
    end else if (inc) begin
      sp_next = sp + 8'd1;
    end else if (dec) begin
      sp_next = sp - 8'd1;
    end else begin
      sp_next = sp;
    end
  end

  // pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= RESET_SP;
    end else begin
      sp <= sp_next;
    end
  end

`ifdef STACK_OVF_EN
  logic wrap_r;
  logic wrap_hit_s;

  assign wrap_hit_s = (inc && (sp == 8'hFF)) || (dec && (sp == 8'h00));

  // sticky wrap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_r <= 1'b0;
    end else if (load) begin
      wrap_r <= 1'b0;
    end else if (wrap_hit_s) begin
      wrap_r <= 1'b1;
    end else begin
      wrap_r <= wrap_r;
    end
  end

  assign wrap = wrap_r;
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: rtl/stack_seq.sv
// 6502 stack-page sequencer: 1/2-byte pushes and pulls, SP load, at {STACK_PAGE, SP}.
// Optional sticky wrap flag on ovf when STACK_OVF_EN is defined.
module stack_seq
  import stack_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = DEF_STACK_PAGE,
  parameter logic [7:0] RESET_SP   = DEF_RESET_SP
) (
  input  logic       ph1,
  input  logic       reset,
  stack_seq_if.slave bus,
  output logic [7:0] sp,
  output logic       ovf
);

  state_e      state_r, state_next_s;
  logic [2:0]  op_r;
  logic [15:0] data_r;
  logic [7:0]  lo_r;
  logic        pull_hi_r;
  logic [15:0] pull_data_r;
  logic        accept_s, inc_s, dec_s, load_s;
  logic [7:0]  sp_next_s;
  logic [15:0] data_src_s;
  logic        ready_r, done_r, we_r, re_r;
  logic [15:0] addr_r;
  logic [7:0]  wdata_r;

  assign accept_s   = bus.cmd_valid && (state_r == ST_IDLE);
  assign data_src_s = accept_s ? bus.cmd_data : data_r;

  stack_ptr #(.RESET_SP(RESET_SP)) u_ptr (
    .clk      (ph1),
    .rst_n    (reset),
    .inc      (inc_s),
    .dec      (dec_s),
    .load     (load_s),
    .load_val (bus.cmd_data[7:0]),
    .sp       (sp),
    .sp_next  (sp_next_s),
    .wrap     (ovf)
  );

  // state register
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state and pointer control
  always_comb begin
    state_next_s = state_r;
    inc_s        = 1'b0;
    dec_s        = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_PUSH1: state_next_s = ST_PUSH_LO;
            OP_PUSH2: state_next_s = ST_PUSH_HI;
            OP_PULL1, OP_PULL2: state_next_s = ST_PULL_RD;
            OP_LOAD: begin
              state_next_s = ST_DONE;
              load_s       = 1'b1;
            end
            default: state_next_s = ST_DONE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PUSH_HI: begin
        dec_s        = 1'b1;
        state_next_s = ST_PUSH_LO;
      end
      ST_PUSH_LO: begin
        dec_s        = 1'b1;
        state_next_s = ST_DONE;
      end
      ST_PULL_RD: begin
        inc_s        = 1'b1;
        state_next_s = ST_PULL_CAP;
      end
      ST_PULL_CAP: begin
        if ((op_r == OP_PULL2) && !pull_hi_r) begin
          state_next_s = ST_PULL_RD;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // command latch and pull-byte capture; pull_data only changes when a pull completes
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      op_r        <= 3'd0;
      data_r      <= 16'h0000;
      lo_r        <= 8'h00;
      pull_hi_r   <= 1'b0;
      pull_data_r <= 16'h0000;
    end else if (accept_s) begin
      op_r      <= bus.cmd_op;
      data_r    <= bus.cmd_data;
      pull_hi_r <= 1'b0;
    end else if (state_r == ST_PULL_CAP) begin
      if ((op_r == OP_PULL2) && !pull_hi_r) begin
        lo_r      <= bus.mem_rdata;
        pull_hi_r <= 1'b1;
      end else if (op_r == OP_PULL2) begin
        pull_data_r <= {bus.mem_rdata, lo_r};
        pull_hi_r   <= 1'b0;
      end else begin
        pull_data_r <= {8'h00, bus.mem_rdata};
      end
    end else begin
      pull_hi_r <= pull_hi_r;
    end
  end

  // outputs registered from the state being entered and the pointer it will hold
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      we_r    <= 1'b0;
      re_r    <= 1'b0;
      addr_r  <= stack_addr(STACK_PAGE, RESET_SP);
      wdata_r <= 8'h00;
    end else begin
      ready_r <= (state_next_s == ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
      we_r    <= (state_next_s == ST_PUSH_HI) || (state_next_s == ST_PUSH_LO);
      re_r    <= (state_next_s == ST_PULL_RD);
      if (state_next_s == ST_PULL_RD) begin
        addr_r <= stack_addr(STACK_PAGE, sp_next_s + 8'd1);
      end else begin
        addr_r <= stack_addr(STACK_PAGE, sp_next_s);
      end
      if (state_next_s == ST_PUSH_HI) begin
        wdata_r <= data_src_s[15:8];
      end else if (state_next_s == ST_PUSH_LO) begin
        wdata_r <= data_src_s[7:0];
      end else begin
        wdata_r <= 8'h00;
      end
    end
  end

  assign bus.cmd_ready = ready_r;
  assign bus.done      = done_r;
  assign bus.mem_we    = we_r;
  assign bus.mem_re    = re_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.pull_data = pull_data_r;

endmodule

// File: tb/tb_stack_seq.sv
// Scoreboard bench for stack_seq: a stack model predicts writes, reads and
// completions; a negedge monitor compares them as the DUT presents them.
module tb_stack_seq;

`ifdef STACK_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct packed {
    logic [31:0] acc;
    logic [31:0] lat;
    logic [15:0] pd;
    logic [7:0]  sp;
    logic        ovf;
  } done_t;

  logic       ph1 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sp;
  logic       ovf;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  stack_seq_if bus();

  stack_seq dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus),
    .sp    (sp),
    .ovf   (ovf)
  );

  always #5 ph1 = ~ph1;

  always @(posedge ph1) cyc <= cyc + 1;

  function automatic logic [7:0] fill(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // environment RAM: 1-cycle synchronous read
  logic [7:0] ram [256];
  always @(posedge ph1) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) ram[i] <= fill(i);
      bus.mem_rdata <= 8'h00;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  // reference model state
  logic [7:0]  m_ram [256];
  logic [7:0]  m_sp;
  logic [15:0] m_pd;
  logic        m_ovf;
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  done_t       exp_done[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic m_push(input logic [7:0] b);
    wr_t w;
    w.addr = {8'h01, m_sp};
    w.data = b;
    exp_wr.push_back(w);
    m_ram[m_sp] = b;
    if (m_sp == 8'h00 && OVF_EN) m_ovf = 1'b1;
    m_sp = m_sp - 8'd1;
  endtask

  task automatic m_pull(output logic [7:0] b);
    if (m_sp == 8'hFF && OVF_EN) m_ovf = 1'b1;
    m_sp = m_sp + 8'd1;
    exp_rd.push_back({8'h01, m_sp});
    b = m_ram[m_sp];
  endtask

  // called at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [2:0] op, input logic [15:0] data);
    int    n;
    int    lat;
    logic [7:0] lo, hi;
    done_t d;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge ph1);
      n++;
    end
    if (!bus.cmd_ready) begin
      flag("ready_timeout");
      bus.cmd_valid = 1'b0;
      return;
    end
    case (op)
      3'd0: begin m_push(data[7:0]); lat = 2; end
      3'd1: begin m_push(data[15:8]); m_push(data[7:0]); lat = 3; end
      3'd2: begin m_pull(lo); m_pd = {8'h00, lo}; lat = 3; end
      3'd3: begin m_pull(lo); m_pull(hi); m_pd = {hi, lo}; lat = 5; end
      3'd4: begin m_sp = data[7:0]; m_ovf = 1'b0; lat = 1; end
      default: lat = 1;
    endcase
    d.acc = cyc;
    d.lat = lat;
    d.pd  = m_pd;
    d.sp  = m_sp;
    d.ovf = m_ovf;
    exp_done.push_back(d);
    @(negedge ph1);
    bus.cmd_valid = 1'b0;
  endtask

  // monitor: pops and compares whenever the DUT presents a strobe or done
  always @(negedge ph1) begin
    if (reset) begin
      if (bus.mem_we || bus.mem_re) chk("we_re_exclusive", {31'b0, bus.mem_we & bus.mem_re}, 32'd0);
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) flag("unexpected_write");
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("write_addr", {16'h0, bus.mem_addr}, {16'h0, w.addr});
          chk("write_data", {24'h0, bus.mem_wdata}, {24'h0, w.data});
        end
      end
      if (bus.mem_re) begin
        if (exp_rd.size() == 0) flag("unexpected_read");
        else chk("read_addr", {16'h0, bus.mem_addr}, {16'h0, exp_rd.pop_front()});
      end
      if (bus.done) begin
        if (exp_done.size() == 0) flag("unexpected_done");
        else begin
          done_t d;
          d = exp_done.pop_front();
          chk("done_latency", cyc - d.acc, d.lat);
          chk("pull_data", {16'h0, bus.pull_data}, {16'h0, d.pd});
          chk("sp_at_done", {24'h0, sp}, {24'h0, d.sp});
          chk("ovf_at_done", {31'h0, ovf}, {31'h0, d.ovf});
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_sp"}, {24'h0, sp}, 32'h0000_00FF);
    chk({tag, "_ready"}, {31'h0, bus.cmd_ready}, 32'd1);
    chk({tag, "_we"}, {31'h0, bus.mem_we}, 32'd0);
    chk({tag, "_re"}, {31'h0, bus.mem_re}, 32'd0);
    chk({tag, "_done"}, {31'h0, bus.done}, 32'd0);
    chk({tag, "_pull_data"}, {16'h0, bus.pull_data}, 32'd0);
    chk({tag, "_ovf"}, {31'h0, ovf}, 32'd0);
  endtask

  initial begin
    logic [7:0] save40, save3f;
    int n;
    for (int i = 0; i < 256; i++) m_ram[i] = fill(i);
    m_sp  = 8'hFF;
    m_pd  = 16'h0000;
    m_ovf = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 16'h0000;

    repeat (3) @(negedge ph1);
    check_reset_state("reset");
    chk("reset_addr", {16'h0, bus.mem_addr}, 32'h0000_01FF);
    reset = 1'b1;
    @(negedge ph1);

    // directed sequence
    issue(3'd0, 16'h0029);
    issue(3'd1, 16'h1234);
    issue(3'd3, 16'h0000);
    issue(3'd4, 16'h0000);
    issue(3'd0, 16'h00AA);
    issue(3'd4, 16'h00FF);
    issue(3'd2, 16'h0000);
    issue(3'd6, 16'hBEEF);

    // abort a PUSH2 while its high byte is on the bus
    issue(3'd4, 16'h0040);
    while (exp_done.size() != 0 && n < 20) begin @(negedge ph1); n++; end
    save40 = m_ram[8'h40];
    save3f = m_ram[8'h3F];
    issue(3'd1, 16'h5A5A);
    #2 reset = 1'b0;
    #1 check_reset_state("abort");
    exp_wr.delete();
    exp_rd.delete();
    exp_done.delete();
    m_ram[8'h40] = save40;
    m_ram[8'h3F] = save3f;
    m_sp  = 8'hFF;
    m_pd  = 16'h0000;
    m_ovf = 1'b0;
    repeat (2) @(negedge ph1);
    reset = 1'b1;
    @(negedge ph1);
    issue(3'd4, 16'h003F);
    issue(3'd3, 16'h0000);

    // randomized back-to-back traffic with occasional idle gaps
    for (int k = 0; k < 200; k++) begin
      issue(3'($urandom_range(0, 7)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge ph1);
    end

    n = 0;
    while ((exp_done.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0) && n < 20) begin
      @(negedge ph1);
      n++;
    end
    if (exp_done.size() != 0) flag("missing_done");
    if (exp_wr.size() != 0) flag("missing_write");
    if (exp_rd.size() != 0) flag("missing_read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
